// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - registered pipeline stage with skid entry and exception/flush squash
module pipe_stage_reg #(
  parameter int INSTR_W = 32,
  parameter int PC_W = 32,
  parameter int EXC_W = 5,
  parameter logic [PC_W-1:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [EXC_W-1:0]   in_exc,
  input  logic               in_bd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic [EXC_W-1:0]   out_exc,
  output logic               out_bd,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               in_fire;
  logic               out_fire;
  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic [EXC_W-1:0]   skid_exc;
  logic               skid_bd;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (in_fire) state_nxt = ST_FULL;
      ST_FULL: begin
        if (in_fire && !out_fire) begin
          state_nxt = ST_SKID;
        end else if (!in_valid && out_fire) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_SKID: if (out_fire) state_nxt = ST_FULL;
      default: state_nxt = ST_EMPTY;
    endcase
    // Squash wins over any handshake; both entries go in one cycle.
    if (req || flush) state_nxt = ST_EMPTY;
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    occupancy = 2'd0;
    case (state)
      ST_FULL: begin
        out_valid = 1'b1;
        occupancy = 2'd1;
      end
      ST_SKID: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
        occupancy = 2'd2;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_instr  <= '0;
      out_pc     <= '0;
      out_exc    <= '0;
      out_bd     <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_exc   <= '0;
      skid_bd    <= 1'b0;
    end else if (req) begin
      out_instr <= '0;
      out_pc    <= HANDLER_PC;
      out_exc   <= '0;
      out_bd    <= 1'b0;
    end else if (flush) begin
      // PC is left in place so the killed path's address stays observable.
      out_instr <= '0;
      out_exc   <= '0;
      out_bd    <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            out_instr <= in_instr;
            out_pc    <= in_pc;
            out_exc   <= in_exc;
            out_bd    <= in_bd;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            out_instr <= in_instr;
            out_pc    <= in_pc;
            out_exc   <= in_exc;
            out_bd    <= in_bd;
          end else if (in_fire) begin
            skid_instr <= in_instr;
            skid_pc    <= in_pc;
            skid_exc   <= in_exc;
            skid_bd    <= in_bd;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            out_instr <= skid_instr;
            out_pc    <= skid_pc;
            out_exc   <= skid_exc;
            out_bd    <= skid_bd;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table, streaming sequence and randomized model check for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam logic [31:0] HPC = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset, req, flush, in_valid, in_ready, out_valid, out_ready, in_bd, out_bd;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [4:0]  in_exc, out_exc;
  logic [1:0]  occupancy;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_exc(out_exc), .out_bd(out_bd),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  exc;
    logic        bd;
  } pl_t;

  typedef struct {
    logic       rst, rq, fl, iv, ordy;
    pl_t        din;
    logic       ev;
    pl_t        e;
    logic       erdy;
    logic [1:0] eocc;
  } vec_t;

  vec_t tbl[$];
  pl_t  q[$];
  pl_t  hold;
  int   total = 0;
  int   bad = 0;

  function automatic pl_t mkp(input logic [31:0] pc, input logic [4:0] exc, input logic bd);
    pl_t p;
    p.instr = {16'hC0DE, pc[15:0]};
    p.pc    = pc;
    p.exc   = exc;
    p.bd    = bd;
    return p;
  endfunction

  task automatic add(input logic rst, rq, fl, iv, ordy, input logic [31:0] ipc,
                     input logic [4:0] iexc, input logic ibd,
                     input logic ev, input logic [31:0] epc, input logic ezi,
                     input logic [4:0] eexc, input logic ebd, input logic erdy,
                     input logic [1:0] eocc);
    vec_t v;
    v.rst = rst; v.rq = rq; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.din = mkp(ipc, iexc, ibd);
    v.ev = ev;
    v.e = mkp(epc, eexc, ebd);
    if (ezi) v.e.instr = '0;
    v.erdy = erdy;
    v.eocc = eocc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, rq, fl, iv, ordy, input pl_t p);
    reset = rst; req = rq; flush = fl; in_valid = iv; out_ready = ordy;
    in_instr = p.instr; in_pc = p.pc; in_exc = p.exc; in_bd = p.bd;
  endtask

  task automatic chk(input string nm, input logic ev, input pl_t e, input logic erdy,
                     input logic [1:0] eocc);
    logic [73:0] act, exp;
    act = {out_valid, out_instr, out_pc, out_exc, out_bd, in_ready, occupancy};
    exp = {ev, e, erdy, eocc};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {valid,instr,pc,exc,bd,in_ready,occ}=%0b,%h,%h,%0d,%0b,%0b,%0d want %0b,%h,%h,%0d,%0b,%0b,%0d",
               nm, out_valid, out_instr, out_pc, out_exc, out_bd, in_ready, occupancy,
               ev, e.instr, e.pc, e.exc, e.bd, erdy, eocc);
    end
  endtask

  // Reference: a FIFO of at most two entries plus whatever the output last showed.
  task automatic model_step(input logic rst, rq, fl, iv, ordy, input pl_t p);
    logic acc, pop;
    if (rst) begin
      q.delete();
      hold = '0;
    end else if (rq) begin
      q.delete();
      hold = '0;
      hold.pc = HPC;
    end else if (fl) begin
      hold.pc = (q.size() > 0) ? q[0].pc : hold.pc;
      hold.instr = '0; hold.exc = '0; hold.bd = 1'b0;
      q.delete();
    end else begin
      acc = iv && (q.size() < 2);
      pop = ordy && (q.size() > 0);
      if (pop) hold = q.pop_front();
      if (acc) q.push_back(p);
    end
  endtask

  task automatic model_chk(input string nm);
    pl_t shown;
    shown = (q.size() > 0) ? q[0] : hold;
    chk(nm, q.size() > 0, shown, q.size() < 2, 2'(q.size()));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pl_t p;
    string nm;
    drive(1, 0, 0, 0, 0, '0);
    @(negedge clk);

    //   rst rq fl iv ordy  in_pc          exc  bd  | ev  pc            zi exc bd rdy occ
    add(1, 0, 0, 0, 0, 32'h0,    0, 0,  0, 32'h0,    1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 32'h3000, 0, 0,  1, 32'h3000, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 32'h3004, 0, 0,  1, 32'h3004, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 32'h3008, 0, 0,  1, 32'h3008, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 32'h0,    0, 0,  0, 32'h3008, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 32'h3000, 0, 0,  1, 32'h3000, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 32'h3004, 0, 0,  1, 32'h3000, 0, 0, 0, 0, 2);
    add(0, 0, 0, 1, 0, 32'h3008, 0, 0,  1, 32'h3000, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 32'h0,    0, 0,  1, 32'h3004, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 32'h0,    0, 0,  0, 32'h3004, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 32'h3000, 0, 0,  1, 32'h3000, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 32'h3004, 0, 0,  1, 32'h3000, 0, 0, 0, 0, 2);
    add(0, 1, 0, 1, 1, 32'h3008, 0, 0,  0, HPC,      1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 32'h3010, 0, 0,  1, 32'h3010, 0, 0, 0, 1, 1);
    add(0, 1, 1, 1, 1, 32'h3014, 0, 0,  0, HPC,      1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 32'h3020, 3, 1,  1, 32'h3020, 0, 3, 1, 1, 1);
    add(0, 0, 1, 1, 1, 32'h3024, 0, 0,  0, 32'h3020, 1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 32'h3010, 12, 1, 1, 32'h3010, 0, 12, 1, 1, 1);
    add(0, 0, 0, 1, 0, 32'h3014, 0, 0,  1, 32'h3010, 0, 12, 1, 0, 2);
    add(1, 1, 0, 1, 1, 32'h3018, 0, 0,  0, 32'h0,    1, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 32'h3030, 0, 0,  1, 32'h3030, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 32'h3034, 0, 0,  1, 32'h3030, 0, 0, 0, 0, 2);
    add(0, 0, 1, 1, 1, 32'h3038, 0, 0,  0, 32'h3030, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,    0, 0,  0, 32'h3030, 1, 0, 0, 1, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].rq, tbl[i].fl, tbl[i].iv, tbl[i].ordy, tbl[i].din);
      @(posedge clk);
      @(negedge clk);
      nm = $sformatf("vec%0d", i);
      chk(nm, tbl[i].ev, tbl[i].e, tbl[i].erdy, tbl[i].eocc);
    end

    // Sustained streaming: each input must appear exactly one cycle later.
    drive(1, 0, 0, 0, 0, '0);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      p = mkp(32'h5000 + 32'(4 * i), 5'(i), i[0]);
      drive(0, 0, 0, 1, 1, p);
      @(posedge clk);
      @(negedge clk);
      nm = $sformatf("stream%0d", i);
      chk(nm, 1'b1, p, 1'b1, 2'd1);
    end

    q.delete();
    hold = '0;
    drive(1, 0, 0, 0, 0, '0);
    @(posedge clk);
    model_step(1, 0, 0, 0, 0, '0);
    @(negedge clk);
    model_chk("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      logic rst, rq, fl, iv, ordy;
      rst  = ($urandom_range(0, 99) < 2);
      rq   = ($urandom_range(0, 99) < 3);
      fl   = ($urandom_range(0, 99) < 3);
      iv   = ($urandom_range(0, 99) < 70);
      ordy = ($urandom_range(0, 99) < 60);
      p.instr = $urandom;
      p.pc    = $urandom;
      p.exc   = 5'($urandom);
      p.bd    = 1'($urandom);
      drive(rst, rq, fl, iv, ordy, p);
      @(posedge clk);
      model_step(rst, rq, fl, iv, ordy, p);
      @(negedge clk);
      nm = $sformatf("rand%0d", i);
      model_chk(nm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter INSTR_W, default 32, instruction payload width.
REQ-002 Parameter PC_W, default 32, PC payload width.
REQ-003 Parameter EXC_W, default 5, exception-code width.
REQ-004 Parameter HANDLER_PC, default 32'h0000_4180, PC presented after an exception request.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 req  input  1  exception/interrupt request; squashes stage and its skid entry.
REQ-008 flush  input  1  squash without PC redirect (e.g. wrong-path kill).
REQ-009 in_valid  input  1  upstream payload valid.
REQ-010 in_ready  output  1  stage can accept; registered, equals "skid entry empty".
REQ-011 in_instr / in_pc / in_exc / in_bd  input  INSTR_W / PC_W / EXC_W / 1  upstream payload.
REQ-012 out_valid  output  1  main entry valid.
REQ-013 out_ready  input  1  downstream accepts.
REQ-014 out_instr / out_pc / out_exc / out_bd  output  INSTR_W / PC_W / EXC_W / 1  main-entry payload, driven directly from flops.
REQ-015 occupancy  output  2  number of held entries, 0..2.

Function
REQ-016 in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-017 Storage: one main entry (drives outputs) plus one skid entry, each holding {instr, pc, exc, bd, valid}.
REQ-018 States: EMPTY (main invalid), FULL (main valid, skid invalid), SKID (both valid); occupancy = 0/1/2 respectively.
REQ-019 EMPTY: in_fire -> main <= input, go FULL; else stay, main payload held.
REQ-020 FULL: in_fire & out_ready -> main <= input, stay FULL.
REQ-021 FULL: !in_valid & out_ready -> main.valid <= 0, go EMPTY; payload fields hold last value.
REQ-022 FULL: in_fire & !out_ready -> skid <= input, go SKID; main unchanged.
REQ-023 FULL: !in_valid & !out_ready -> stay, all fields held.
REQ-024 SKID: in_ready = 0; out_ready -> main <= skid, skid.valid <= 0, go FULL; else hold.
REQ-025 Order preserved: no payload overtakes an earlier one; no payload dropped or duplicated absent req/flush/reset.
REQ-026 Zero-bubble throughput: sustained in_valid & out_ready gives one transfer per cycle, latency exactly 1 cycle input-to-output.
REQ-027 Payload passes unmodified; exc and bd travel with their instruction.
REQ-028 Priority per cycle: reset > req > flush > handshake update.
REQ-029 req: main <= {instr 0, pc HANDLER_PC, exc 0, bd 0, valid 0}; skid.valid <= 0; state EMPTY; concurrent in_valid ignored.
REQ-030 flush: main.valid <= 0, out_instr <= 0, out_exc <= 0, out_bd <= 0, out_pc held; skid.valid <= 0; state EMPTY; concurrent in_valid ignored.
REQ-031 req/flush in SKID drop both entries in the same cycle.
REQ-032 in_ready during req/flush cycle reflects pre-edge state; input accepted that cycle is discarded by REQ-029/030.

Reset
REQ-033 reset: out_valid 0, out_instr 0, out_pc 0, out_exc 0, out_bd 0, skid cleared, in_ready 1, occupancy 0, state EMPTY.
REQ-034 reset mid-operation (any state) takes effect at next edge and overrides req, flush, handshakes.

Verification
REQ-035 Streaming: in_valid=1, out_ready=1, pc 0x3000,0x3004,0x3008 -> out_pc same sequence one cycle later, occupancy 1, in_ready 1 throughout.
REQ-036 Backpressure: FULL with pc 0x3000, out_ready=0, in pc 0x3004 -> occupancy 2, in_ready 0; out_ready=1 next cycles -> outputs 0x3000 then 0x3004, no loss.
REQ-037 Exception request in SKID: req=1 -> next cycle out_pc 0x4180, out_instr 0, out_valid 0, occupancy 0, in_ready 1.
REQ-038 Flush vs req same cycle: both asserted -> HANDLER_PC result of REQ-029.
REQ-039 Payload integrity: in_exc 5'd12, in_bd 1 with pc 0x3010 -> appears unchanged on out_exc/out_bd/out_pc together.
REQ-040 Reset during SKID with req=1 -> all outputs zero (out_pc 0, not 0x4180), in_ready 1.
